// File: rtl/fifo_in_arb.sv
// fifo_in_arb: round-robin arbiter feeding one registered beat per cycle into the fifo write port.
// Optional per-owner burst grants are compiled in with FIFO_IN_ARB_BURST_EN.
module fifo_in_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_vld,
  output logic [NUM_REQ-1:0]            req_rdy,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic                          data_in_vld,
  input  logic                          data_in_rdy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);
  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0]         ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  vld_q, vld_d;
  logic [IW-1:0]         gid_q, gid_d;

  logic [IW-1:0] rr_win, win;
  logic          rr_vld, win_vld;
  logic          load_ok, acc;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    if (int'(i) == NUM_REQ - 1) return '0;
    return i + 1'b1;
  endfunction

  // Rotating priority search; descending loop so the closest-to-ptr hit wins.
  always_comb begin
    logic [IW-1:0] cand;
    rr_vld = 1'b0;
    rr_win = '0;
    cand   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IW'((int'(ptr_q) + i) % NUM_REQ);
      if (req_vld[cand]) begin
        rr_vld = 1'b1;
        rr_win = cand;
      end
    end
  end

  assign load_ok = !vld_q || data_in_rdy;
  assign acc     = rst && win_vld && load_ok;

  // Ready goes only to the current winner, and only when the slot can take it.
  always_comb begin
    req_rdy = '0;
    if (acc) req_rdy[win] = 1'b1;
  end

  // Output slot: load on accept, otherwise empty out once the fifo takes it.
  always_comb begin
    dat_d = dat_q;
    gid_d = gid_q;
    vld_d = vld_q;
    if (acc) begin
      dat_d = req_data[win*DATA_WIDTH +: DATA_WIDTH];
      gid_d = win;
      vld_d = 1'b1;
    end else if (vld_q && data_in_rdy) begin
      vld_d = 1'b0;
    end
  end

`ifdef FIFO_IN_ARB_BURST_EN
  typedef enum logic {IDLE, BURST} state_t;
  state_t        st_q, st_d;
  logic [IW-1:0] own_q, own_d;
  logic [7:0]    cnt_q, cnt_d;

  // Owner keeps the grant for up to MAX_BURST beats or until it goes idle.
  always_comb begin
    win_vld = rr_vld;
    win     = rr_win;
    st_d    = st_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    if (st_q == BURST) begin
      win_vld = req_vld[own_q];
      win     = own_q;
    end
    if (rst && load_ok) begin
      unique case (st_q)
        IDLE: begin
          if (win_vld) begin
            if (MAX_BURST == 1) begin
              ptr_d = nxt(win);
            end else begin
              st_d  = BURST;
              own_d = win;
              cnt_d = 8'd1;
            end
          end
        end
        BURST: begin
          if (win_vld && cnt_q + 8'd1 != 8'(MAX_BURST)) begin
            cnt_d = cnt_q + 8'd1;
          end else begin
            st_d  = IDLE;
            cnt_d = '0;
            ptr_d = nxt(own_q);
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

  // Burst state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q  <= IDLE;
      own_q <= '0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      own_q <= own_d;
      cnt_q <= cnt_d;
    end
  end
`else
  // Strict per-beat round robin: pointer moves past every accepted winner.
  always_comb begin
    win_vld = rr_vld;
    win     = rr_win;
    ptr_d   = acc ? nxt(rr_win) : ptr_q;
  end
`endif

  // Slot and pointer registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
      dat_q <= '0;
      vld_q <= 1'b0;
      gid_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      dat_q <= dat_d;
      vld_q <= vld_d;
      gid_q <= gid_d;
    end
  end

  assign data_in     = dat_q;
  assign data_in_vld = vld_q;
  assign grant_id    = gid_q;
endmodule

// File: doc/fifo_in_arb.md
# fifo_in_arb

Round-robin arbiter sharing the `fifo` write port among `NUM_REQ` independent valid/ready producers. Each cycle it grants at most one requester, registers the granted beat into a one-entry output stage, and drives the fifo's `data_in`/`data_in_vld`/`data_in_rdy` handshake. It sits directly in front of `fifo` in the top-level, replacing the single `fifo_in_if` driver when several sources feed one fifo.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..16)
- `DATA_WIDTH`, 8, beat width; must match `fifo` data width
- `MAX_BURST`, 4, beats per grant when burst mode is compiled in (1..255)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous reset, active-low
- `req_data`  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- `req_vld`  in  NUM_REQ  per-requester valid
- `req_rdy`  out  NUM_REQ  per-requester ready, one-hot or zero
- `data_in`  out  DATA_WIDTH  beat to fifo, registered
- `data_in_vld`  out  1  beat valid to fifo, registered
- `data_in_rdy`  in  1  fifo ready
- `grant_id`  out  $clog2(NUM_REQ)  index of requester owning the current `data_in` beat, registered

## Operation
- Output stage (`data_in`, `data_in_vld`, `grant_id`) is a single register slot. `load_ok = !data_in_vld || data_in_rdy`.
- Priority pointer `ptr`: winner = first i with `req_vld[i]=1` searching `ptr, ptr+1, ... ptr+NUM_REQ-1` modulo NUM_REQ.
- `req_rdy[winner] = load_ok`; all other `req_rdy` = 0. If no `req_vld`, `req_rdy` = 0.
- Accept = `req_vld[w] && req_rdy[w]`. On accept: slot loads `req_data[w]`, `grant_id<=w`, `data_in_vld<=1`.
- Slot drains when `data_in_vld && data_in_rdy`; if no accept the same cycle, `data_in_vld<=0`; `data_in` and `grant_id` keep last value.
- Pointer update (burst mode off): on accept, `ptr <= (w+1) mod NUM_REQ`; otherwise unchanged.
- `req_rdy` depends combinationally on `req_vld` and `data_in_rdy`; no combinational path from `req_data` to outputs.
- Requester beats are never dropped or duplicated; order within one requester is preserved.

## Timing
- Reset (`rst=0` at a rising edge): `data_in_vld=0`, `data_in=0`, `grant_id=0`, `ptr=0`, burst state IDLE, `burst_cnt=0`. While `rst=0`, `req_rdy=0`. Reset mid-transfer discards the slot contents; no beat is presented after reset until a new accept.
- Latency: accept at edge N -> `data_in_vld=1` after edge N, visible in cycle N+1.
- Throughput: 1 beat/cycle with `data_in_rdy` held high (simultaneous drain and load).
- Backpressure: `data_in_rdy=0` with full slot -> `data_in`, `data_in_vld`, `grant_id` stable; all `req_rdy=0`; `ptr` unchanged.
- Fifo full then ready: first cycle `data_in_rdy=1` drains the slot and accepts the next winner in the same cycle.
- Pointer wrap: winner `NUM_REQ-1` -> `ptr=0`.

## Configuration
- `FIFO_IN_ARB_BURST_EN` defined: two-state FSM IDLE/BURST with 8-bit `burst_cnt`.
  - IDLE: on accept from w -> BURST, owner=w, `burst_cnt=1`; if `MAX_BURST=1`, stay IDLE and advance `ptr` to w+1.
  - BURST: owner has absolute priority; each owner accept increments `burst_cnt`. Exit to IDLE and set `ptr<=owner+1` when the owner accepts beat number `MAX_BURST`, or when `req_vld[owner]=0` in a cycle where `load_ok=1` (no other requester accepted that cycle; arbitration resumes next cycle).
  - Backpressure (`load_ok=0`) freezes state and `burst_cnt`.
- Not defined: no FSM, no `burst_cnt`; pointer advances after every accept (strict per-beat round robin).

## Test plan
- Reset: hold `rst=0` 3 cycles with all `req_vld=1` -> `req_rdy=0`, `data_in_vld=0`, `grant_id=0`; first beat appears cycle after `rst=1` from requester 0.
- Per-beat RR (macro off, NUM_REQ=4): all requesters valid, `data_in_rdy=1`, requester i sends 0x10*i+k -> fifo sees grant_id sequence 0,1,2,3,0,... and data 0x00,0x10,0x20,0x30,0x01,...
- Sparse requests: only requesters 1 and 3 valid -> alternating 1,3,1,3; requester 2 raising valid while ptr=2 wins next.
- Backpressure: `data_in_rdy=0` for 5 cycles with slot full -> outputs stable, all `req_rdy=0`, no beat lost; release -> data stream resumes with zero bubbles.
- Burst (macro on, MAX_BURST=4): all valid -> grant_id 0,0,0,0,1,1,1,1,2,...; requester 0 drops valid after 2 beats -> next beat from requester 1, `ptr=1`.
- Reset mid-burst: `rst=0` while slot full and in BURST -> next cycle `data_in_vld=0`, state IDLE, `ptr=0`.
